// File: rtl/sha256_msg_padder.sv
// FIPS 180-4 message padder: streams big-endian words into the scheduler's
// 16-word block memory, appends 0x80, zero fill and the bit length, then waits for the core.
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [2:0]  in_nbytes,
  output logic [31:0] message_word_out,
  output logic [3:0]  message_word_addr,
  output logic        write_enable_out,
  output logic        block_ready,
  output logic        last_block,
  input  logic        block_done,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LOAD, PAD, LEN_HI, LEN_LO, WAIT_ACK} state_e;

  typedef struct packed {
    logic pad80;        // 0x80000000 word still owed
    logic extra;        // current block closes with zeros; length goes in the next one
    logic last;         // block in WAIT_ACK carries the length words
    logic resume_load;  // after the ack, more message words are expected
  } ctl_t;

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  ctl_t             ctl_q, ctl_d;

  logic [2:0]       nb;
  logic [5:0]       inc;
  logic [3:0]       idx_nx;
  logic             pad_need;
  logic [63:0]      len64;

  function automatic logic [31:0] mask_last(input logic [31:0] d, input logic [2:0] n);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      if (n == 3'd4 || b < int'(n)) w[31-8*b -: 8] = d[31-8*b -: 8];
      else if (b == int'(n))         w[31-8*b -: 8] = 8'h80;
    end
    return w;
  endfunction

  assign nb       = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
  assign inc      = in_last ? {nb, 3'b000} : 6'd32;
  assign idx_nx   = idx_q + 4'd1;
  assign pad_need = in_last && (nb == 3'd4);
  assign len64    = 64'(len_q);

  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    len_d             = len_q;
    ctl_d             = ctl_q;
    in_ready          = 1'b0;
    write_enable_out  = 1'b0;
    message_word_addr = 4'd0;
    message_word_out  = 32'd0;
    block_ready       = 1'b0;
    last_block        = 1'b0;
    busy              = 1'b0;
    if (reset) begin
      in_ready = 1'b1;
    end else begin
      message_word_addr = idx_q;
      busy              = (state_q != IDLE);
      case (state_q)
        IDLE, LOAD: begin
          in_ready = 1'b1;
          if (in_valid) begin
            write_enable_out = 1'b1;
            message_word_out = in_last ? mask_last(in_data, nb) : in_data;
            idx_d            = idx_nx;
            len_d            = ((state_q == IDLE) ? '0 : len_q) + LEN_W'(inc);
            state_d          = LOAD;
            ctl_d.pad80      = pad_need;
            ctl_d.extra      = 1'b0;
            ctl_d.last       = 1'b0;
            if (!in_last) begin
              ctl_d.resume_load = 1'b1;
              if (idx_q == 4'd15) state_d = WAIT_ACK;
            end else begin
              ctl_d.resume_load = 1'b0;
              // Room left in this block decides whether the length fits here.
              if (idx_nx == 4'd0)
                state_d = WAIT_ACK;
              else if (!pad_need && idx_nx == 4'd14)
                state_d = LEN_HI;
              else if ({1'b0, idx_nx} + {4'b0, pad_need} <= 5'd14)
                state_d = PAD;
              else begin
                state_d     = PAD;
                ctl_d.extra = 1'b1;
              end
            end
          end
        end
        PAD: begin
          write_enable_out = 1'b1;
          message_word_out = ctl_q.pad80 ? 32'h8000_0000 : 32'h0;
          ctl_d.pad80      = 1'b0;
          idx_d            = idx_nx;
          if (ctl_q.extra) begin
            if (idx_q == 4'd15) begin
              state_d           = WAIT_ACK;
              ctl_d.extra       = 1'b0;
              ctl_d.resume_load = 1'b0;
            end
          end else if (idx_q == 4'd13) begin
            state_d = LEN_HI;
          end
        end
        LEN_HI: begin
          write_enable_out  = 1'b1;
          message_word_addr = 4'd14;
          message_word_out  = len64[63:32];
          idx_d             = 4'd15;
          state_d           = LEN_LO;
        end
        LEN_LO: begin
          write_enable_out  = 1'b1;
          message_word_addr = 4'd15;
          message_word_out  = len64[31:0];
          idx_d             = 4'd0;
          ctl_d.last        = 1'b1;
          state_d           = WAIT_ACK;
        end
        WAIT_ACK: begin
          block_ready = 1'b1;
          last_block  = ctl_q.last;
          if (block_done) begin
            if (ctl_q.last) begin
              state_d = IDLE;
              len_d   = '0;
              ctl_d   = '0;
            end else begin
              state_d = ctl_q.resume_load ? LOAD : PAD;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      ctl_q   <= ctl_d;
    end
  end

endmodule
